// File: rtl/gf180mcu_osu_sc_gp12t3v3__rrarb4_1.sv
// Round-robin arbiter for N requesters with a bounded grant tenure and a one-cycle gap after every release.
// Defining GF180MCU_OSU_SC_ARB_LOCK_EN adds a LOCK input that suppresses the tenure timeout.
module gf180mcu_osu_sc_gp12t3v3__rrarb4_1 #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 15
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         REQ,
    input  logic                 DONE,
`ifdef GF180MCU_OSU_SC_ARB_LOCK_EN
    input  logic                 LOCK,
`endif
    output logic [N-1:0]         GNT,
    output logic [$clog2(N)-1:0] GID,
    output logic                 BUSY,
    output logic                 TIMEOUT
);
    localparam int IW    = $clog2(N);
    localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     gnt_reg, gnt_next;
    logic [IW-1:0]    gid_reg, gid_next;
    logic             busy_reg, busy_next;
    logic             timeout_reg, timeout_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IW-1:0]    ptr_reg, ptr_next;

    logic [N-1:0]     rot;
    logic [IW-1:0]    win_off;
    logic [IW-1:0]    win_idx;
    logic [N-1:0]     win_onehot;
    logic             lock;
    logic             req_held;
    logic             at_last;
    logic             tmo_hit;

`ifdef GF180MCU_OSU_SC_ARB_LOCK_EN
    assign lock = LOCK;
`else
    assign lock = 1'b0;
`endif

    // rot[k] is the request of the requester k+1 places after the pointer.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = REQ[IW'((int'(ptr_reg) + 1 + gi) % N)];
        end
    endgenerate

    always_comb begin
        win_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                win_off = IW'(i);
            end
        end
    end

    assign win_idx = IW'((int'(ptr_reg) + 1 + int'(win_off)) % N);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == IW'(gi));
        end
    endgenerate

    assign req_held = REQ[gid_reg];
    assign at_last  = (HOLD_MAX > 0) && (cnt_reg == CNT_LAST);
    assign tmo_hit  = at_last && !lock;

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        gid_next     = gid_reg;
        busy_next    = busy_reg;
        timeout_next = 1'b0;
        cnt_next     = cnt_reg;
        ptr_next     = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|REQ) begin
                    state_next = GRANT;
                    gnt_next   = win_onehot;
                    gid_next   = win_idx;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                end
            end
            GRANT: begin
                // A DONE or dropped request wins over a coincident timeout.
                if (DONE || !req_held || tmo_hit) begin
                    state_next   = IDLE;
                    gnt_next     = '0;
                    busy_next    = 1'b0;
                    ptr_next     = gid_reg;
                    cnt_next     = '0;
                    timeout_next = !DONE && req_held;
                end else if (!at_last) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            gid_reg     <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
            ptr_reg     <= IW'(N - 1);
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            gid_reg     <= gid_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
            cnt_reg     <= cnt_next;
            ptr_reg     <= ptr_next;
        end
    end

    assign GNT     = gnt_reg;
    assign GID     = gid_reg;
    assign BUSY    = busy_reg;
    assign TIMEOUT = timeout_reg;
endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__rrarb4_1.md
GF180MCU_OSU_SC_GP12T3V3__RRARB4_1 -- requirements
Module: gf180mcu_osu_sc_gp12t3v3__rrarb4_1

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter HOLD_MAX, default 15: maximum grant tenure in cycles; 0 disables the timeout; legal range 0..255.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 REQ  input  N  request vector; bit i is requester i.
REQ-006 DONE  input  1  current grantee releases the resource.
REQ-007 GNT  output  N  registered one-hot grant; all-zero when idle.
REQ-008 GID  output  clog2(N)  registered index of the current or last grantee.
REQ-009 BUSY  output  1  registered; high exactly when GNT is nonzero.
REQ-010 TIMEOUT  output  1  registered one-cycle pulse on forced release.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 In IDLE with REQ nonzero at edge k, the block SHALL enter GRANT and assert GNT[w] after edge k, where w is the first set REQ bit searching upward from PTR+1 modulo N.
REQ-013 In IDLE with REQ all-zero, the block SHALL stay in IDLE with GNT=0.
REQ-014 In GRANT, GNT, GID and PTR SHALL hold constant while REQ[GID]=1, DONE=0 and no timeout occurs.
REQ-015 In GRANT, a release SHALL occur at edge k if DONE=1, REQ[GID]=0, or a timeout occurs; after edge k: state IDLE, GNT=0, BUSY=0, PTR=GID.
REQ-016 After every release, GNT SHALL be zero for exactly one cycle; no direct grantee-to-grantee handoff.
REQ-017 Tenure counter: SHALL be 0 on GRANT entry and increment once per GRANT cycle; width clog2(HOLD_MAX+1), minimum 1.
REQ-018 When HOLD_MAX>0 and the counter equals HOLD_MAX-1 at an edge with no other release cause, the block SHALL release and assert TIMEOUT for the following cycle only.
REQ-019 With HOLD_MAX>0, a grant SHALL last at most HOLD_MAX cycles.
REQ-020 If DONE or REQ drop coincide with the timeout edge, the release SHALL be treated as normal; TIMEOUT SHALL stay 0.
REQ-021 The PTR search SHALL wrap from N-1 to 0; a lone requester SHALL be regranted after each one-cycle gap.
REQ-022 REQ changes in IDLE SHALL affect only the next arbitration edge; GNT SHALL never contain more than one set bit.
REQ-023 GID SHALL retain its last value while in IDLE.

Reset
REQ-024 RST=1 at an edge SHALL force: state IDLE, GNT=0, BUSY=0, GID=0, TIMEOUT=0, counter 0, PTR=N-1.
REQ-025 RST SHALL take priority over every other input, including during GRANT; the first grant after reset SHALL favour requester 0.

Configuration
REQ-026 Macro GF180MCU_OSU_SC_ARB_LOCK_EN, when defined, SHALL add port LOCK (input, 1) after DONE.
REQ-027 With the macro defined and LOCK=1 in GRANT, timeout SHALL be suppressed and the counter SHALL saturate at HOLD_MAX-1; DONE and REQ drop still release; timeout resumes on the first edge with LOCK=0.
REQ-028 Without the macro, no LOCK port SHALL exist and behaviour SHALL equal LOCK=0.

Verification
REQ-029 Reset, then REQ=4'b1111 held, DONE pulsed each GRANT cycle -> GNT sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-030 HOLD_MAX=15, REQ=4'b0100 held, DONE=0 -> GNT=0100 for exactly 15 cycles, then GNT=0000 with TIMEOUT=1 for one cycle, then GNT=0100 again.
REQ-031 Grant held by requester 2; DONE=1 on the edge where the counter equals 14 -> release with TIMEOUT=0.
REQ-032 RST=1 while GNT=0010 -> next cycle GNT=0, GID=0, BUSY=0; then REQ=4'b1010 -> GNT=0010.
REQ-033 With GF180MCU_OSU_SC_ARB_LOCK_EN, LOCK=1, REQ=4'b0001 for 40 cycles -> GNT=0001 throughout, TIMEOUT=0; LOCK=0 -> release on the next edge, TIMEOUT=1.
REQ-034 PTR=3 and REQ=4'b1001 in IDLE -> GNT=0001 (wrap).
